// File: rtl/llc_pipe_pkg.sv
// Shared definitions for the LLC pipeline buffering FIFOs: pointer/count
// width helpers, the generic entry template and the stage payload layouts.
package llc_pipe_pkg;

  // Reference configuration used by the stage payload typedefs
  localparam int LLC_FIFO_DEPTH = 4;
  localparam int LLC_DATA_WIDTH = 64;
  localparam int LLC_SET_BITS   = 8;

  // Pointer width: index bits plus one wrap bit; also wide enough for a count 0..depth
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LLC_PTR_W = ptr_width(LLC_FIFO_DEPTH);
  localparam int LLC_CNT_W = LLC_PTR_W;

  // Generic FIFO entry: payload plus the set index it targets
  typedef struct packed {
    logic [LLC_DATA_WIDTH-1:0] data;
    logic [LLC_SET_BITS-1:0]   set_idx;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_EVICT = 2'd2,
    OP_FILL  = 2'd3
  } llc_op_t;

  // decode -> read-set / read-mem payload (replaces fifo_mem_packet)
  typedef struct packed {
    llc_op_t     op;
    logic [45:0] tag;
    logic [15:0] req_id;
  } mem_packet_t;

  // lookup -> process payload (replaces fifo_mem_lookup_packet)
  typedef struct packed {
    llc_op_t     op;
    logic        hit;
    logic [2:0]  way;
    logic [41:0] tag;
    logic [15:0] req_id;
  } lookup_packet_t;

endpackage

// File: rtl/llc_set_match.sv
// Set-hazard comparator: matches every valid stored set against probe_set
// and reports whether any matched plus how many did.
module llc_set_match
  import llc_pipe_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SET_BITS = 8,
  localparam int CNT_W   = ptr_width(DEPTH)
) (
  input  logic [DEPTH*SET_BITS-1:0] entry_sets,
  input  logic [DEPTH-1:0]          entry_valid,
  input  logic [SET_BITS-1:0]       probe_set,
  output logic                      hit,
  output logic [CNT_W-1:0]          count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Population count of valid entries whose set equals probe_set
  always_comb begin
    count = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_sets[i*SET_BITS +: SET_BITS] == probe_set)) begin
        count = count + CNT_ONE;
      end else begin
        count = count;
      end
    end
    hit = (count != {CNT_W{1'b0}});
  end

endmodule

// File: rtl/llc_pipe_fifo.sv
// Set-aware valid/ready FIFO between LLC pipeline stages. Circular buffer
// with wrap-bit pointers, per-entry valid bits, synchronous flush and a
// combinational set-hazard probe for the input decoder.
// Optional feature macro: LLC_PIPE_FIFO_BYPASS_EN (fall-through when empty).
module llc_pipe_fifo
  import llc_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int SET_BITS   = 8,
  localparam int PTR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [SET_BITS-1:0]   push_set,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [SET_BITS-1:0]   pop_set,
  output logic [PTR_W-1:0]      usage,
  output logic                  full,
  output logic                  empty,
  input  logic [SET_BITS-1:0]   probe_set,
  output logic                  probe_hit,
  output logic [PTR_W-1:0]      probe_count
);

  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {(PTR_W-1){1'b0}}};
  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]     mem_data [DEPTH];
  logic [SET_BITS-1:0]       mem_set  [DEPTH];
  logic [DEPTH-1:0]          valid;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [IDX_W-1:0]          wr_idx;
  logic [IDX_W-1:0]          rd_idx;
  logic                      byp;
  logic                      push_fire;
  logic                      pop_fire;
  logic                      wr_en;
  logic                      rd_en;
  logic [DEPTH-1:0]          wr_mask;
  logic [DEPTH-1:0]          rd_mask;
  logic [DEPTH*SET_BITS-1:0] set_flat;

  // Occupancy status derived from the registered pointers
  always_comb begin
    usage      = wr_ptr - rd_ptr;
    empty      = (wr_ptr == rd_ptr);
    full       = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    push_ready = !full && !flush;
    wr_idx     = wr_ptr[IDX_W-1:0];
    rd_idx     = rd_ptr[IDX_W-1:0];
  end

  // Head presentation, optional fall-through, and handshake decode
  always_comb begin
`ifdef LLC_PIPE_FIFO_BYPASS_EN
    byp       = empty && push_valid && !flush;
    pop_valid = !empty || byp;
    if (byp) begin
      pop_data = push_data;
      pop_set  = push_set;
    end else begin
      pop_data = mem_data[rd_idx];
      pop_set  = mem_set[rd_idx];
    end
`else
    byp       = 1'b0;
    pop_valid = !empty;
    pop_data  = mem_data[rd_idx];
    pop_set   = mem_set[rd_idx];
`endif
    push_fire = push_valid && push_ready;
    pop_fire  = pop_valid && pop_ready && !flush;
    // A fall-through entry taken in the same cycle never lands in storage
    wr_en     = push_fire && !(byp && pop_ready);
    rd_en     = pop_fire && !empty;
    wr_mask   = wr_en ? (ONE_HOT0 << wr_idx) : {DEPTH{1'b0}};
    rd_mask   = rd_en ? (ONE_HOT0 << rd_idx) : {DEPTH{1'b0}};
  end

  // Pointer and per-entry valid-bit state; flush wins over push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      valid  <= {DEPTH{1'b0}};
    end else if (flush) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      valid  <= {DEPTH{1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      valid <= (valid & ~rd_mask) | wr_mask;
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= {DATA_WIDTH{1'b0}};
        mem_set[i]  <= {SET_BITS{1'b0}};
      end
    end else if (wr_en) begin
      mem_data[wr_idx] <= push_data;
      mem_set[wr_idx]  <= push_set;
    end
  end

  // Flatten stored sets for the hazard comparator
  always_comb begin
    set_flat = {(DEPTH*SET_BITS){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      set_flat[i*SET_BITS +: SET_BITS] = mem_set[i];
    end
  end

  llc_set_match #(
    .DEPTH    (DEPTH),
    .SET_BITS (SET_BITS)
  ) u_set_match (
    .entry_sets  (set_flat),
    .entry_valid (valid),
    .probe_set   (probe_set),
    .hit         (probe_hit),
    .count       (probe_count)
  );

endmodule

// File: tb/tb_llc_pipe_fifo.sv
// Self-checking bench for llc_pipe_fifo: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_llc_pipe_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int SB    = 8;
  localparam int CW    = 3;
`ifdef LLC_PIPE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic [SB-1:0] push_set = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic [SB-1:0] pop_set;
  logic [CW-1:0] usage;
  logic          full;
  logic          empty;
  logic [SB-1:0] probe_set = '0;
  logic          probe_hit;
  logic [CW-1:0] probe_count;

  typedef struct {
    logic [DW-1:0] d;
    logic [SB-1:0] s;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  llc_pipe_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SET_BITS(SB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data), .push_set(push_set),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data), .pop_set(pop_set),
    .usage(usage), .full(full), .empty(empty),
    .probe_set(probe_set), .probe_hit(probe_hit), .probe_count(probe_count)
  );

  always #5 clk = ~clk;

  function automatic int model_count(input logic [SB-1:0] ps);
    int c;
    c = 0;
    foreach (mq[i]) if (mq[i].s == ps) c++;
    return c;
  endfunction

  // One clock of stimulus; the model decides acceptance from its own occupancy
  task automatic drive_cycle(input logic pv, input logic [DW-1:0] pd, input logic [SB-1:0] ps,
                             input logic pr, input logic fl);
    int   n;
    bit   byp, acc_push, acc_pop;
    ent_t e;
    push_valid = pv; push_data = pd; push_set = ps; pop_ready = pr; flush = fl;
    n        = mq.size();
    byp      = BYP && (n == 0) && pv && !fl;
    acc_push = pv && (n < DEPTH) && !fl;
    acc_pop  = pr && !fl && ((n > 0) || byp);
    @(posedge clk);
    if (fl) mq.delete();
    else if (!(byp && pr)) begin
      if (acc_pop) void'(mq.pop_front());
      if (acc_push) begin e.d = pd; e.s = ps; mq.push_back(e); end
    end
    #1;
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (usage !== 3'd0) begin n_fail++; $display("FAIL rst_usage: got %0d expected 0", usage); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b expected 0", full); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL rst_push_ready: got %b expected 1", push_ready); end
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pop_valid: got %b expected 0", pop_valid); end
    n_checks++; if (probe_hit !== 1'b0 || probe_count !== 3'd0) begin n_fail++; $display("FAIL rst_probe: got %b/%0d expected 0/0", probe_hit, probe_count); end
    n_checks++; if (pop_data !== 64'd0 || pop_set !== 8'd0) begin n_fail++; $display("FAIL rst_pop_data: got %h/%h expected 0/0", pop_data, pop_set); end
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (empty !== 1'b1 || push_ready !== 1'b1) begin n_fail++; $display("FAIL idle_state: got empty=%b ready=%b expected 1/1", empty, push_ready); end
  endtask

  task automatic test_fill();
    logic [SB-1:0] fs [4];
    logic [DW-1:0] d;
    fs[0] = 8'h11; fs[1] = 8'h22; fs[2] = 8'h33; fs[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      d = {$urandom, $urandom};
      drive_cycle(1'b1, d, fs[k], 1'b0, 1'b0);
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL fill_push_ready: got %b expected 0", push_ready); end
    n_checks++; if (usage !== 3'd4) begin n_fail++; $display("FAIL fill_usage: got %0d expected 4", usage); end
    drive_cycle(1'b1, 64'hDEAD_BEEF, 8'h55, 1'b0, 1'b0);
    n_checks++; if (usage !== CW'(mq.size())) begin n_fail++; $display("FAIL fill_drop: got %0d expected %0d", usage, mq.size()); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (pop_set !== fs[k] || pop_data !== mq[0].d) begin n_fail++; $display("FAIL fill_order%0d: got %h/%h expected %h/%h", k, pop_set, pop_data, fs[k], mq[0].d); end
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    n_checks++; if (empty !== 1'b1 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got empty=%b pv=%b expected 1/0", empty, pop_valid); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d;
    drive_cycle(1'b1, {$urandom, $urandom}, SB'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      exp_d = mq[0].d;
      n_checks++; if (pop_data !== exp_d || pop_valid !== 1'b1) begin n_fail++; $display("FAIL stream_head%0d: got %h pv=%b expected %h", k, pop_data, pop_valid, exp_d); end
      drive_cycle(1'b1, {$urandom, $urandom}, SB'($urandom), 1'b1, 1'b0);
      n_checks++; if (usage !== 3'd1) begin n_fail++; $display("FAIL stream_usage%0d: got %0d expected 1", k, usage); end
    end
    n_checks++; if (pop_data !== mq[0].d) begin n_fail++; $display("FAIL stream_last: got %h expected %h", pop_data, mq[0].d); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_probe();
    drive_cycle(1'b1, 64'h1, 8'h05, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h2, 8'h07, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h3, 8'h05, 1'b0, 1'b0);
    probe_set = 8'h05; #1;
    n_checks++; if (probe_hit !== 1'b1 || probe_count !== CW'(model_count(8'h05))) begin n_fail++; $display("FAIL probe_two: got %b/%0d expected 1/%0d", probe_hit, probe_count, model_count(8'h05)); end
    // in-flight push not counted, in-flight pop still counted
    push_valid = 1'b1; push_set = 8'h05; pop_ready = 1'b1; #1;
    n_checks++; if (probe_count !== CW'(model_count(8'h05))) begin n_fail++; $display("FAIL probe_inflight: got %0d expected %0d", probe_count, model_count(8'h05)); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (probe_count !== CW'(model_count(8'h05)) || probe_hit !== 1'b1) begin n_fail++; $display("FAIL probe_after_pop: got %b/%0d expected 1/%0d", probe_hit, probe_count, model_count(8'h05)); end
    probe_set = 8'h09; #1;
    n_checks++; if (probe_hit !== 1'b0 || probe_count !== 3'd0) begin n_fail++; $display("FAIL probe_miss: got %b/%0d expected 0/0", probe_hit, probe_count); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 64'hA1, 8'h21, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'hA2, 8'h22, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'hA3, 8'h23, 1'b0, 1'b0);
    probe_set = 8'h66;
    flush = 1'b1; #1;
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", push_ready); end
    drive_cycle(1'b1, 64'hFF, 8'h66, 1'b1, 1'b1);
    n_checks++; if (empty !== 1'b1 || usage !== CW'(mq.size())) begin n_fail++; $display("FAIL flush_empty: got %b/%0d expected 1/%0d", empty, usage, mq.size()); end
    n_checks++; if (probe_count !== 3'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL flush_absent: got cnt=%0d pv=%b expected 0/0", probe_count, pop_valid); end
  endtask

  task automatic test_latency();
    push_valid = 1'b1; push_data = 64'hABCD; push_set = 8'h3C; pop_ready = 1'b1; #1;
`ifdef LLC_PIPE_FIFO_BYPASS_EN
    n_checks++; if (pop_valid !== 1'b1 || pop_data !== 64'hABCD) begin n_fail++; $display("FAIL byp_same_cycle: got pv=%b %h expected 1/abcd", pop_valid, pop_data); end
    drive_cycle(1'b1, 64'hABCD, 8'h3C, 1'b1, 1'b0);
    n_checks++; if (usage !== 3'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL byp_consumed: got usage=%0d pv=%b expected 0/0", usage, pop_valid); end
`else
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL lat_same_cycle: got pv=%b expected 0", pop_valid); end
    drive_cycle(1'b1, 64'hABCD, 8'h3C, 1'b1, 1'b0);
    n_checks++; if (pop_valid !== 1'b1 || pop_data !== 64'hABCD || usage !== 3'd1) begin n_fail++; $display("FAIL lat_next_cycle: got pv=%b %h usage=%0d expected 1/abcd/1", pop_valid, pop_data, usage); end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
`endif
    n_checks++; if (usage !== CW'(mq.size())) begin n_fail++; $display("FAIL lat_final: got %0d expected %0d", usage, mq.size()); end
  endtask

  task automatic test_midreset();
    drive_cycle(1'b1, 64'h77, 8'h01, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h78, 8'h01, 1'b0, 1'b0);
    rst = 1'b0; #1;
    mq.delete();
    n_checks++; if (empty !== 1'b1 || usage !== 3'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL midreset: got empty=%b usage=%0d pv=%b expected 1/0/0", empty, usage, pop_valid); end
    @(negedge clk); rst = 1'b1; #1;
  endtask

  task automatic test_random();
    logic pv, pr, fl;
    for (int k = 0; k < 300; k++) begin
      pv = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 19) == 0);
      probe_set = SB'($urandom_range(0, 3));
      drive_cycle(pv, {$urandom, $urandom}, SB'($urandom_range(0, 3)), pr, fl);
      n_checks++; if (usage !== CW'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_status%0d: got %0d/%b/%b expected %0d", k, usage, empty, full, mq.size()); end
      n_checks++; if (pop_valid !== (mq.size() > 0) || push_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_hs%0d: got pv=%b pr=%b expected size %0d", k, pop_valid, push_ready, mq.size()); end
      n_checks++; if (probe_count !== CW'(model_count(probe_set)) || probe_hit !== (model_count(probe_set) > 0)) begin n_fail++; $display("FAIL rnd_probe%0d: got %b/%0d expected %0d", k, probe_hit, probe_count, model_count(probe_set)); end
      if (mq.size() > 0) begin
        n_checks++; if (pop_data !== mq[0].d || pop_set !== mq[0].s) begin n_fail++; $display("FAIL rnd_head%0d: got %h/%h expected %h/%h", k, pop_data, pop_set, mq[0].d, mq[0].s); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_probe();
    test_flush();
    test_latency();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
